// File: rtl/sram_bank_array_pkg.sv
// sram_bank_pkg: shared types and helpers for the banked SRAM core.
//   BYTE_W       lane width in bits
//   ST_*         legacy state encodings behind bank_state_t
//   clog2/max2   elaboration-time sizing helpers
package sram_bank_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [1:0] ST_ACTIVE = 2'd0;
   localparam logic [1:0] ST_SLEEP  = 2'd1;
   localparam logic [1:0] ST_WAKE   = 2'd2;

   typedef enum logic [1:0] {
      ACTIVE = ST_ACTIVE,
      SLEEP  = ST_SLEEP,
      WAKE   = ST_WAKE
   } bank_state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sram_bank_array_if.sv
// sram_bank_array_if: request/response bus of the banked SRAM core.
//   req_valid/req_ready  handshake, accept = valid & ready
//   req_write/addr/be/wdata  request payload (addr MSBs select the bank)
//   rsp_valid/rsp_rdata  read response, one pulse per accepted read
//   master: requester side, slave: SRAM core side
interface sram_bank_array_if
   import sram_bank_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned LANES     = 4,
   parameter int unsigned WORD_AW   = 13
);
   localparam int unsigned AW     = WORD_AW + clog2(NUM_BANKS);
   localparam int unsigned DATA_W = BYTE_W * LANES;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [AW-1:0]     req_addr;
   logic [LANES-1:0]  req_be;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_be, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_be, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/sram_bank_array_ctrl.sv
// sram_bank_ctrl: per-bank idle-driven sleep FSM.
//   clk, rst_n     clock, async active-low reset
//   sel_i          a valid request addresses this bank (starts a wake)
//   acc_i          a request to this bank is accepted this cycle
//   bank_busy_o    bank cannot accept (SLEEP or WAKE)
//   bank_sleep_o   bank is in SLEEP
// IDLE_CYCLES = 0 removes the FSM: the bank is permanently ACTIVE.
module sram_bank_ctrl
   import sram_bank_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 64,
   parameter int unsigned WAKE_CYCLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sel_i,
   input  logic acc_i,
   output logic bank_busy_o,
   output logic bank_sleep_o
);

   localparam int unsigned CNT_W = clog2(max2(IDLE_CYCLES, WAKE_CYCLES)) + 1;

   generate
      if (IDLE_CYCLES == 0) begin : g_no_sleep
         logic unused_in;
         assign unused_in    = sel_i ^ acc_i ^ clk ^ rst_n;
         assign bank_busy_o  = 1'b0;
         assign bank_sleep_o = 1'b0;
      end else begin : g_fsm
         bank_state_t      state_q, state_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;

         // One counter serves as idle counter in ACTIVE and wake counter in WAKE.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
               ACTIVE: begin
                  if (acc_i) begin
                     cnt_d = '0;
                  end else if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
                     state_d = SLEEP;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               SLEEP: begin
                  if (sel_i) begin
                     state_d = WAKE;
                     cnt_d   = '0;
                  end
               end
               WAKE: begin
                  if (cnt_q == CNT_W'(WAKE_CYCLES - 1)) begin
                     state_d = ACTIVE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_d = ACTIVE;
                  cnt_d   = '0;
               end
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= ACTIVE;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         assign bank_busy_o  = (state_q != ACTIVE);
         assign bank_sleep_o = (state_q == SLEEP);
      end
   endgenerate

endmodule

// File: rtl/sram_bank_array.sv
// sram_bank_array: NUM_BANKS x LANES banked SRAM core of single-port 8-bit macros.
//   clk, rst_n   clock, async active-low reset
//   bus          slave side of sram_bank_array_if (request + read response)
//   bank_sleep   per-bank SLEEP indication
// Optional macro SRAM_RSP_REG_EN adds an output register (read latency 2).
module sram_bank_array
   import sram_bank_pkg::*;
#(
   parameter int unsigned NUM_BANKS   = 2,
   parameter int unsigned LANES       = 4,
   parameter int unsigned WORD_AW     = 13,
   parameter int unsigned IDLE_CYCLES = 64,
   parameter int unsigned WAKE_CYCLES = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sram_bank_array_if.slave     bus,
   output logic [NUM_BANKS-1:0] bank_sleep
);

   localparam int unsigned BANK_W = clog2(NUM_BANKS);
   localparam int unsigned SEL_W  = (BANK_W > 0) ? BANK_W : 1;
   localparam int unsigned DATA_W = BYTE_W * LANES;
   localparam int unsigned DEPTH  = 1 << WORD_AW;

   logic [SEL_W-1:0]                    req_bank;
   logic [WORD_AW-1:0]                  word_addr;
   logic [NUM_BANKS-1:0]                bank_busy;
   logic                                accept;
   logic [NUM_BANKS-1:0][DATA_W-1:0]    bank_dout;

   generate
      if (NUM_BANKS > 1) begin : g_bank_dec
         assign req_bank = bus.req_addr[WORD_AW +: BANK_W];
      end else begin : g_single_bank
         assign req_bank = '0;
      end
   endgenerate

   assign word_addr     = bus.req_addr[WORD_AW-1:0];
   assign bus.req_ready = ~bank_busy[req_bank];
   assign accept        = bus.req_valid & bus.req_ready;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic bank_hit;
      assign bank_hit = (req_bank == SEL_W'(b));

      sram_bank_ctrl #(
         .IDLE_CYCLES (IDLE_CYCLES),
         .WAKE_CYCLES (WAKE_CYCLES)
      ) u_ctrl (
         .clk          (clk),
         .rst_n        (rst_n),
         .sel_i        (bus.req_valid & bank_hit),
         .acc_i        (accept & bank_hit),
         .bank_busy_o  (bank_busy[b]),
         .bank_sleep_o (bank_sleep[b])
      );

      for (genvar l = 0; l < LANES; l++) begin : g_lane
         logic              lane_csn;
         logic [BYTE_W-1:0] mem [DEPTH];
         logic [BYTE_W-1:0] dout_q;

         // Disabled write lanes stay deselected so their held read data survives.
         assign lane_csn = ~(accept & bank_hit & (~bus.req_write | bus.req_be[l]));

         always_ff @(posedge clk) begin
            if (!lane_csn) begin
               if (bus.req_write) mem[word_addr] <= bus.req_wdata[BYTE_W*l +: BYTE_W];
               else               dout_q         <= mem[word_addr];
            end
         end

         assign bank_dout[b][BYTE_W*l +: BYTE_W] = dout_q;
      end
   end

   // Macro outputs are not reset; rd_any_q masks them to zero until the first read.
   logic             rd_vld_q, rd_vld_d;
   logic             rd_any_q, rd_any_d;
   logic [SEL_W-1:0] rd_bank_q, rd_bank_d;
   logic [DATA_W-1:0] rd_word;

   always_comb begin
      rd_vld_d  = accept & ~bus.req_write;
      rd_any_d  = rd_any_q | rd_vld_d;
      rd_bank_d = rd_vld_d ? req_bank : rd_bank_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_any_q  <= 1'b0;
         rd_bank_q <= '0;
      end else begin
         rd_vld_q  <= rd_vld_d;
         rd_any_q  <= rd_any_d;
         rd_bank_q <= rd_bank_d;
      end
   end

   assign rd_word = rd_any_q ? bank_dout[rd_bank_q] : '0;

`ifdef SRAM_RSP_REG_EN
   logic              rsp_vld_q, rsp_vld_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   always_comb begin
      rsp_vld_d  = rd_vld_q;
      rsp_data_d = rd_vld_q ? rd_word : rsp_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign bus.rsp_valid = rsp_vld_q;
   assign bus.rsp_rdata = rsp_data_q;
`else
   assign bus.rsp_valid = rd_vld_q;
   assign bus.rsp_rdata = rd_word;
`endif

endmodule

// File: tb/tb_sram_bank_array.sv
// tb_sram_bank_array: randomized self-checking bench for sram_bank_array.
// A byte-addressed memory model and per-bank "last accept" times predict
// read data, response timing, sleep state and wake stall length.
module tb_sram_bank_array;
   import sram_bank_pkg::*;

   localparam int IDLE = 64;
   localparam int WAKE = 3;
`ifdef SRAM_RSP_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk;
   logic       rst_n;
   logic [1:0] bank_sleep;
   logic [1:0] bank_sleep0;

   sram_bank_array_if #(.NUM_BANKS(2), .LANES(4), .WORD_AW(13)) bus  ();
   sram_bank_array_if #(.NUM_BANKS(2), .LANES(4), .WORD_AW(13)) bus0 ();

   sram_bank_array #(
      .NUM_BANKS(2), .LANES(4), .WORD_AW(13), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .bank_sleep(bank_sleep)
   );

   sram_bank_array #(
      .NUM_BANKS(2), .LANES(4), .WORD_AW(13), .IDLE_CYCLES(0), .WAKE_CYCLES(WAKE)
   ) dut_nosleep (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .bank_sleep(bank_sleep0)
   );

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          last_acc [2];
   logic [7:0]  refm [int];
   exp_t        expq [$];
   logic [31:0] last_rsp = '0;
   logic [13:0] pool [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Response monitor: ordering, data, latency, and hold while idle.
   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         last_rsp = '0;
      end else if (bus.rsp_valid) begin : rsp_blk
         exp_t e;
         if (expq.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
         end else begin
            e = expq.pop_front();
            chk("rsp_data", bus.rsp_rdata, e.data);
            chk("rsp_latency", cyc, e.due);
         end
         last_rsp = bus.rsp_rdata;
      end else begin
         chk("rsp_hold", bus.rsp_rdata, last_rsp);
      end
   end

   // Issue one request at posedge+1 and wait (bounded) for its acceptance.
   task automatic do_req(input bit wr, input logic [13:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
      int          b;
      bit          asleep;
      int          stalls;
      bit          ok;
      logic [31:0] w;
      exp_t        e;
      b      = int'(addr[13]);
      asleep = (cyc - last_acc[b]) >= IDLE;
      stalls = 0;
      ok     = 0;
      chk("sleep_pre", 64'(bank_sleep[b]), 64'(asleep));
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_be    = be;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1;
            break;
         end
         stalls++;
      end
      chk("req_accept", 64'(ok), 1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      last_acc[b] = cyc;
      // A sleeping bank stalls one SLEEP cycle plus WAKE cycles.
      chk("stall_cycles", stalls, asleep ? (WAKE + 1) : 0);
      if (wr) begin
         for (int l = 0; l < 4; l++)
            if (be[l]) refm[int'(addr) * 4 + l] = wd[8*l +: 8];
      end else begin
         for (int l = 0; l < 4; l++)
            w[8*l +: 8] = refm.exists(int'(addr) * 4 + l) ? refm[int'(addr) * 4 + l] : 8'h00;
         e.data = w;
         e.due  = cyc + LAT - 1;
         expq.push_back(e);
      end
   endtask

   // Caller is at a negedge; resets both DUTs and checks reset values.
   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk("rst_ready", 64'(bus.req_ready), 1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_bank_sleep", bank_sleep, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_acc[0] = cyc;
      last_acc[1] = cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      logic [13:0] a;
      int          r;
      int          gap;
      bit          bad_s;
      bit          bad_r;

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_be     = '0;
      bus.req_wdata  = '0;
      bus0.req_valid = 1'b0;
      bus0.req_write = 1'b0;
      bus0.req_addr  = '0;
      bus0.req_be    = '0;
      bus0.req_wdata = '0;

      @(negedge clk);
      do_reset();

      // Full write then read back.
      do_req(1, 14'h0010, 4'hF, 32'hA5A5_1234);
      do_req(0, 14'h0010, 4'h0, 32'h0);
      repeat (LAT + 1) @(posedge clk);
      #1;
      chk("full_word_read", bus.rsp_rdata, 32'hA5A5_1234);

      // Partial byte-enable merge.
      do_req(1, 14'h0020, 4'hF, 32'hFFFF_FFFF);
      do_req(1, 14'h0020, 4'b0001, 32'h0000_00AB);
      do_req(1, 14'h0020, 4'h0, 32'h1234_5678);
      do_req(0, 14'h0020, 4'h0, 32'h0);
      repeat (LAT + 1) @(posedge clk);
      #1;
      chk("be_merge_read", bus.rsp_rdata, 32'hFFFF_FFAB);

      // Same word offset in both banks, back-to-back reads.
      do_req(1, 14'h0005, 4'hF, 32'h0BAD_0000);
      do_req(1, 14'h2005, 4'hF, 32'h0BAD_0001);
      do_req(0, 14'h0005, 4'h0, 32'h0);
      do_req(0, 14'h2005, 4'h0, 32'h0);
      repeat (LAT + 1) @(posedge clk);
      #1;
      chk("b2b_last_read", bus.rsp_rdata, 32'h0BAD_0001);

      // Idle into sleep right after reset, then wake bank1.
      @(negedge clk);
      do_reset();
      repeat (62) @(posedge clk);
      #1;
      chk("sleep_not_yet", bank_sleep, 2'b00);
      @(posedge clk);
      #1;
      chk("sleep_after_idle", bank_sleep, 2'b11);
      do_req(0, 14'h2005, 4'h0, 32'h0);
      chk("bank0_still_asleep", bank_sleep, 2'b01);

      // Reset while bank0 is waking.
      bus.req_write = 1'b0;
      bus.req_addr  = 14'h0005;
      bus.req_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("wake_ready_low", 64'(bus.req_ready), 0);
      chk("wake_not_sleep", 64'(bank_sleep[0]), 0);
      do_reset();
      chk("post_reset_sleep", bank_sleep, 2'b00);
      do_req(0, 14'h0005, 4'h0, 32'h0);
      repeat (LAT + 1) @(posedge clk);
      #1;
      chk("data_kept_over_reset", bus.rsp_rdata, 32'h0BAD_0000);

      // Randomized traffic with occasional long gaps that put banks to sleep.
      for (int i = 0; i < 24; i++) begin
         a = 14'($urandom_range(0, 16383));
         do_req(1, a, 4'hF, $urandom);
         pool.push_back(a);
      end
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 19);
         gap = (r == 0) ? (IDLE + $urandom_range(0, 10)) : (r < 6) ? $urandom_range(1, 3) : 0;
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 1) == 1) begin
               a = pool[$urandom_range(0, pool.size() - 1)];
               do_req(1, a, 4'($urandom_range(0, 15)), $urandom);
            end else begin
               a = 14'($urandom_range(0, 16383));
               do_req(1, a, 4'hF, $urandom);
               pool.push_back(a);
            end
         end else begin
            a = pool[$urandom_range(0, pool.size() - 1)];
            do_req(0, a, 4'($urandom_range(0, 15)), $urandom);
         end
      end
      repeat (LAT + 2) @(posedge clk);
      #1;
      chk("rsp_drained", expq.size(), 0);

      // Sleep-disabled instance must never sleep or stall.
      bad_s = 0;
      bad_r = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bank_sleep0 !== 2'b00) bad_s = 1;
         if (bus0.req_ready !== 1'b1) bad_r = 1;
      end
      chk("nosleep_bank_sleep", 64'(bad_s), 0);
      chk("nosleep_req_ready", 64'(bad_r), 0);
      chk("long_idle_sleep", bank_sleep, 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
